// File: rtl/regwrite_decode_stage.sv
`default_nettype none
// ============================================================================
// Module : regwrite_decode_stage
// Desc   : Registered register-file write-back port: one-hot 5:32 write-enable
//          decode, write data, and write-back-to-decode bypass flags.
//          Option macro REGWR_X31_WRITABLE_EN makes register 31 writable.
// Rev    : 1.0  initial release
// ============================================================================
module regwrite_decode_stage #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RegWrite,
  input  logic [ADDR_W-1:0]    Rd,
  input  logic [DATA_W-1:0]    WrData,
  input  logic                 hold,
  input  logic                 flush,
  input  logic [ADDR_W-1:0]    Rn,
  input  logic [ADDR_W-1:0]    Rm,
  output logic [2**ADDR_W-1:0] WrSel,
  output logic [DATA_W-1:0]    WrDataOut,
  output logic                 Fwd1,
  output logic                 Fwd2
);

  localparam int LO_W = (ADDR_W + 1) / 2;
  localparam int HI_W = ADDR_W - LO_W;
  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZR_ADDR = {ADDR_W{1'b1}};

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              wen;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!hold) begin
      valid_d = RegWrite;
      addr_d  = Rd;
      data_d  = WrData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

`ifdef REGWR_X31_WRITABLE_EN
  assign wen = valid_q;
`else
  // Register 31 reads as zero (XZR), so writes to it are dropped here.
  assign wen = valid_q && (addr_q != ZR_ADDR);
`endif

  // Two-level decode: upper address bits gate eight-way groups of the lower decode.
  logic [2**HI_W-1:0] hi_dec;
  logic [2**LO_W-1:0] lo_dec;

  for (genvar k = 0; k < 2**HI_W; k++) begin : g_hi_dec
    assign hi_dec[k] = wen && (addr_q[ADDR_W-1:LO_W] == HI_W'(k));
  end

  for (genvar j = 0; j < 2**LO_W; j++) begin : g_lo_dec
    assign lo_dec[j] = (addr_q[LO_W-1:0] == LO_W'(j));
  end

  for (genvar i = 0; i < NREG; i++) begin : g_sel
    localparam int HI_IDX = i >> LO_W;
    localparam int LO_IDX = i & ((2**LO_W) - 1);
    assign WrSel[i] = hi_dec[HI_IDX] & lo_dec[LO_IDX];
  end

  assign WrDataOut = data_q;
  assign Fwd1      = wen && (addr_q == Rn);
  assign Fwd2      = wen && (addr_q == Rm);

endmodule
`default_nettype wire

// File: tb/tb_regwrite_decode_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_regwrite_decode_stage
// Desc   : Scoreboard bench for regwrite_decode_stage (REGWR_X31_WRITABLE_EN aware).
// Rev    : 1.0  initial release
// ============================================================================
module tb_regwrite_decode_stage;

`ifdef REGWR_X31_WRITABLE_EN
  localparam bit X31_WR = 1'b1;
`else
  localparam bit X31_WR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  Rd;
  logic [63:0] WrData;
  logic        hold;
  logic        flush;
  logic [4:0]  Rn;
  logic [4:0]  Rm;
  logic [31:0] WrSel;
  logic [63:0] WrDataOut;
  logic        Fwd1;
  logic        Fwd2;

  regwrite_decode_stage #(.DATA_W(64), .ADDR_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .RegWrite  (RegWrite),
    .Rd        (Rd),
    .WrData    (WrData),
    .hold      (hold),
    .flush     (flush),
    .Rn        (Rn),
    .Rm        (Rm),
    .WrSel     (WrSel),
    .WrDataOut (WrDataOut),
    .Fwd1      (Fwd1),
    .Fwd2      (Fwd2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sel;
    logic [63:0] data;
    logic        f1;
    logic        f2;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference stage-register state
  logic        m_valid = 1'b0;
  logic [4:0]  m_addr  = '0;
  logic [63:0] m_data  = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one request, model the edge, then set read addresses and queue the expectation.
  task automatic cyc(input logic rst, input logic rw, input logic [4:0] rd,
                     input logic [63:0] d, input logic hld, input logic fl,
                     input logic [4:0] rn, input logic [4:0] rm);
    exp_t e;
    logic wen_m;
    reset = rst; RegWrite = rw; Rd = rd; WrData = d; hold = hld; flush = fl;
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_addr = '0; m_data = '0;
    end else if (fl) begin
      m_valid = 1'b0;
    end else if (!hld) begin
      m_valid = rw; m_addr = rd; m_data = d;
    end
    #1;
    Rn = rn; Rm = rm;
    wen_m  = m_valid && ((m_addr != 5'd31) || X31_WR);
    e.sel  = wen_m ? (32'h1 << m_addr) : 32'h0;
    e.data = m_data;
    e.f1   = wen_m && (m_addr == rn);
    e.f2   = wen_m && (m_addr == rm);
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("wrsel",   64'(WrSel),     64'(e.sel));
      check("wrdata",  WrDataOut,      e.data);
      check("fwd1",    64'(Fwd1),      64'(e.f1));
      check("fwd2",    64'(Fwd2),      64'(e.f2));
      check("onehot0", 64'($onehot0(WrSel)), 64'd1);
    end
  end

  initial begin
    reset = 1'b1; RegWrite = 1'b0; Rd = '0; WrData = '0;
    hold = 1'b0; flush = 1'b0; Rn = '0; Rm = '0;

    // Reset held for two edges with a live request on the inputs
    cyc(1, 1, 5'd5, 64'h5555, 0, 0, 5'd5, 5'd5);
    cyc(1, 1, 5'd5, 64'h5555, 0, 0, 5'd5, 5'd5);
    cyc(0, 1, 5'd5, 64'hAAAA_0000_5555_FFFF, 0, 0, 5'd5, 5'd0);

    // Single write then idle
    cyc(0, 1, 5'd7, 64'hDEAD_BEEF_0123_4567, 0, 0, 5'd1, 5'd7);
    cyc(0, 0, 5'd7, 64'h0, 0, 0, 5'd7, 5'd7);

    // Address sweep
    for (int r = 0; r < 32; r++)
      cyc(0, 1, 5'(r), {32'hC0DE_0000, 32'(r)}, 0, 0, 5'(r), 5'(31 - r));
    cyc(0, 0, 5'd0, 64'h0, 0, 0, 5'd0, 5'd0);

    // Hold keeps the captured write while new requests are ignored
    cyc(0, 1, 5'd3,  64'h11, 0, 0, 5'd3, 5'd9);
    cyc(0, 1, 5'd9,  64'h99, 1, 0, 5'd9, 5'd3);
    cyc(0, 1, 5'd10, 64'hAA, 1, 0, 5'd10, 5'd3);
    cyc(0, 1, 5'd9,  64'h99, 1, 0, 5'd3, 5'd10);
    cyc(0, 0, 5'd0,  64'h0,  0, 0, 5'd0, 5'd0);

    // Flush beats hold; data field is retained
    cyc(0, 1, 5'd12, 64'h1212, 0, 0, 5'd12, 5'd0);
    cyc(0, 1, 5'd13, 64'h1313, 1, 1, 5'd12, 5'd13);
    cyc(0, 1, 5'd4,  64'h4444, 0, 0, 5'd4, 5'd12);

    // Forwarding, including a read-address change mid-cycle
    cyc(0, 1, 5'd6, 64'h6666, 0, 0, 5'd6, 5'd2);
    @(negedge clk);
    #2;
    Rm = 5'd6;
    #1;
    check("fwd2_rm_change", 64'(Fwd2), 64'd1);
    check("fwd1_rm_change", 64'(Fwd1), 64'd1);
    cyc(0, 1, 5'd31, 64'h3131, 0, 0, 5'd31, 5'd31);
    cyc(0, 1, 5'd31, 64'h3232, 0, 0, 5'd31, 5'd0);

    // Reset mid-stream discards the request on that edge
    cyc(0, 1, 5'd8, 64'h8888, 0, 0, 5'd8, 5'd8);
    cyc(1, 1, 5'd9, 64'h9999, 0, 0, 5'd9, 5'd9);
    cyc(0, 0, 5'd9, 64'h0, 0, 0, 5'd9, 5'd0);
    cyc(0, 1, 5'd1, 64'h0101, 0, 0, 5'd1, 5'd1);

    repeat (3) @(negedge clk);
    #1;
    check("scoreboard_drain", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
